// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with explicit fill count, programmable thresholds,
// sticky overflow/underflow flags and selectable standard or first-word-fall-through reads.
module fifo_param_sync #(
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 16,
  parameter int ALM_FULL_TH  = DEPTH - 2,
  parameter int ALM_EMPTY_TH = 2,
  parameter int FWFT         = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wren,
  input  logic [DATA_W-1:0]          i_wrdata,
  input  logic                       i_rden,
  input  logic                       i_clr_err,
  output logic [DATA_W-1:0]          o_rddata,
  output logic                       o_rdvalid,
  output logic                       o_full,
  output logic                       o_alm_full,
  output logic                       o_empty,
  output logic                       o_alm_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(ALM_FULL_TH);
  localparam logic [CW-1:0] AE_TH_C = CW'(ALM_EMPTY_TH);

  if (DATA_W < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH ||
      ALM_EMPTY_TH < 0 || ALM_EMPTY_TH > DEPTH - 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_param_err
    $error("fifo_param_sync: illegal parameter combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              full_reg, alm_full_reg, empty_reg, alm_empty_reg;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic [DATA_W-1:0] rddata_reg;
  logic              rdvalid_reg;
  logic              rd_acc, wr_acc;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  always_comb begin
    rd_acc         = i_rden && !empty_reg;
    wr_acc         = i_wren && (!full_reg || rd_acc);
    wr_ptr_next    = wr_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next    = rd_acc ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next     = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
    // An error event on the same edge as a clear leaves the flag set.
    overflow_next  = (i_wren && !wr_acc) ? 1'b1 : (i_clr_err ? 1'b0 : overflow_reg);
    underflow_next = (i_rden && empty_reg) ? 1'b1 : (i_clr_err ? 1'b0 : underflow_reg);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      alm_full_reg  <= 1'b0;
      empty_reg     <= 1'b1;
      alm_empty_reg <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == DEPTH_C);
      alm_full_reg  <= (count_next >= AF_TH_C);
      empty_reg     <= (count_next == '0);
      alm_empty_reg <= (count_next <= AE_TH_C);
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= i_wrdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Prefetch the post-edge head; forward write data when that slot is written now.
    always_ff @(posedge clk) begin
      if (!reset) begin
        rddata_reg  <= '0;
        rdvalid_reg <= 1'b0;
      end else begin
        rdvalid_reg <= (count_next != '0);
        if (wr_acc && (wr_ptr_reg == rd_ptr_next)) rddata_reg <= i_wrdata;
        else                                        rddata_reg <= mem[rd_ptr_next];
      end
    end
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (!reset) begin
        rddata_reg  <= '0;
        rdvalid_reg <= 1'b0;
      end else begin
        rdvalid_reg <= rd_acc;
        if (rd_acc) rddata_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign o_rddata    = rddata_reg;
  assign o_rdvalid   = rdvalid_reg;
  assign o_full      = full_reg;
  assign o_alm_full  = alm_full_reg;
  assign o_empty     = empty_reg;
  assign o_alm_empty = alm_empty_reg;
  assign o_count     = count_reg;
  assign o_overflow  = overflow_reg;
  assign o_underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_param_sync.sv
// Directed bench: one standard-mode and one FWFT instance, default DEPTH=16, DATA_W=128.
module tb_fifo_param_sync;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_wren, s_rden, s_clr;
  logic [127:0] s_wrdata;
  logic [127:0] s_rddata;
  logic         s_rdvalid, s_full, s_alm_full, s_empty, s_alm_empty, s_ovf, s_udf;
  logic [4:0]   s_count;
  logic         f_wren, f_rden, f_clr;
  logic [127:0] f_wrdata;
  logic [127:0] f_rddata;
  logic         f_rdvalid, f_full, f_alm_full, f_empty, f_alm_empty, f_ovf, f_udf;
  logic [4:0]   f_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_param_sync #(.FWFT(0)) u_std (
    .clk(clk), .reset(reset), .i_wren(s_wren), .i_wrdata(s_wrdata), .i_rden(s_rden),
    .i_clr_err(s_clr), .o_rddata(s_rddata), .o_rdvalid(s_rdvalid), .o_full(s_full),
    .o_alm_full(s_alm_full), .o_empty(s_empty), .o_alm_empty(s_alm_empty),
    .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  fifo_param_sync #(.FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .i_wren(f_wren), .i_wrdata(f_wrdata), .i_rden(f_rden),
    .i_clr_err(f_clr), .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_full(f_full),
    .o_alm_full(f_alm_full), .o_empty(f_empty), .o_alm_empty(f_alm_empty),
    .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    s_wren = 1'b1; s_rden = 1'b0; s_clr = 1'b0; s_wrdata = 128'h99;
    f_wren = 1'b1; f_rden = 1'b0; f_clr = 1'b0; f_wrdata = 128'h99;

    // Reset held for 3 cycles with writes requested
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_count", s_count, 0);
      chk("rst_fcount", f_count, 0);
    end
    chk("rst_empty", s_empty, 1);
    chk("rst_alm_empty", s_alm_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_alm_full", s_alm_full, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("rst_rdvalid", s_rdvalid, 0);
    chk("rst_rddata", s_rddata, 0);
    chk("rst_frdvalid", f_rdvalid, 0);
    $display("reset: count=%0d empty=%0b", s_count, s_empty);
    s_wren = 1'b0; f_wren = 1'b0;
    reset = 1'b1;
    step();
    chk("idle_count", s_count, 0);

    // Fill with 1..16 then one rejected write
    for (int i = 1; i <= 16; i++) begin
      s_wren = 1'b1; s_wrdata = 128'(i);
      step();
      chk("fill_count", s_count, 128'(i));
      chk("fill_alm_full", s_alm_full, (i >= 14) ? 1 : 0);
      chk("fill_full", s_full, (i == 16) ? 1 : 0);
      chk("fill_alm_empty", s_alm_empty, (i <= 2) ? 1 : 0);
      chk("fill_empty", s_empty, 0);
      $display("write %0h: count=%0d", i, s_count);
    end
    s_wrdata = 128'h11;
    step();
    chk("extra_ovf", s_ovf, 1);
    chk("extra_count", s_count, 16);
    s_wren = 1'b0;

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      s_rden = 1'b1;
      step();
      chk("drain_rdvalid", s_rdvalid, 1);
      chk("drain_rddata", s_rddata, 128'(i));
      chk("drain_count", s_count, 128'(16 - i));
      $display("read: data=%0h count=%0d", s_rddata, s_count);
    end
    s_rden = 1'b0;
    step();
    chk("drain_rdvalid_end", s_rdvalid, 0);
    chk("drain_hold", s_rddata, 128'h10);
    chk("drain_empty", s_empty, 1);
    chk("drain_udf", s_udf, 0);

    // Clear overflow
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    chk("clr_ovf", s_ovf, 0);

    // Refill then 20 cycles of simultaneous read+write at full
    for (int i = 0; i < 16; i++) begin
      s_wren = 1'b1; s_wrdata = 128'(256 + i);
      step();
    end
    chk("refill_full", s_full, 1);
    for (int k = 0; k < 20; k++) begin
      s_wren = 1'b1; s_rden = 1'b1; s_wrdata = 128'(272 + k);
      step();
      chk("rw_count", s_count, 16);
      chk("rw_full", s_full, 1);
      chk("rw_ovf", s_ovf, 0);
      chk("rw_rddata", s_rddata, 128'(256 + k));
      $display("rw %0d: data=%0h count=%0d", k, s_rddata, s_count);
    end
    s_wren = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("rw_drain", s_rddata, 128'(276 + k));
    end
    s_rden = 1'b0;
    step();
    chk("rw_drain_empty", s_empty, 1);

    // Simultaneous read+write into empty
    s_wren = 1'b1; s_rden = 1'b1; s_wrdata = 128'hAA;
    step();
    chk("erw_udf", s_udf, 1);
    chk("erw_count", s_count, 1);
    chk("erw_empty", s_empty, 0);
    chk("erw_rdvalid", s_rdvalid, 0);
    s_wren = 1'b0;
    step();
    chk("erw_rddata", s_rddata, 128'hAA);
    chk("erw_rdvalid2", s_rdvalid, 1);
    chk("erw_count2", s_count, 0);
    s_rden = 1'b0; s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    chk("clr_udf", s_udf, 0);
    $display("empty rw: udf cleared=%0b", !s_udf);

    // Overflow coincident with clear keeps the flag
    for (int i = 0; i < 16; i++) begin
      s_wren = 1'b1; s_wrdata = 128'(i);
      step();
    end
    s_clr = 1'b1;
    step();
    chk("ovf_vs_clr", s_ovf, 1);
    s_wren = 1'b0;
    step();
    s_clr = 1'b0;
    chk("ovf_clr_after", s_ovf, 0);

    // FWFT instance
    f_wren = 1'b1; f_wrdata = 128'h55;
    step();
    chk("fwft_data", f_rddata, 128'h55);
    chk("fwft_valid", f_rdvalid, 1);
    chk("fwft_empty", f_empty, 0);
    f_wrdata = 128'h66;
    step();
    chk("fwft_head_hold", f_rddata, 128'h55);
    f_wren = 1'b0; f_rden = 1'b1;
    step();
    chk("fwft_pop1", f_rddata, 128'h66);
    chk("fwft_pop1_count", f_count, 1);
    step();
    chk("fwft_pop2_empty", f_empty, 1);
    chk("fwft_pop2_valid", f_rdvalid, 0);
    f_rden = 1'b0; f_wren = 1'b1; f_wrdata = 128'h77;
    step();
    f_rden = 1'b1; f_wrdata = 128'h88;
    step();
    chk("fwft_bypass", f_rddata, 128'h88);
    chk("fwft_bypass_count", f_count, 1);
    chk("fwft_udf", f_udf, 0);
    $display("fwft: data=%0h count=%0d", f_rddata, f_count);
    f_wren = 1'b0; f_rden = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
